tpx3_data_in_tx: RTL and testbench



---
 rtl/tpx3_tx_pkg.sv | 20 ++
 rtl/tpx3_data_in_tx_if.sv | 18 +
 rtl/tpx3_tx_shifter.sv | 39 +++
 rtl/tpx3_data_in_tx.sv | 145 ++++++++++++++
 tb/tb_tpx3_data_in_tx.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/tpx3_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tpx3_tx_pkg
// Brief   : Shared types and constants for the Timepix3 DataIn transmitter.
// Revision: 1.0 - initial release
// ============================================================================
package tpx3_tx_pkg;

    localparam int c_byte_w = 8;
    localparam int c_bcnt_w = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_TRAIL = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/tpx3_data_in_tx_if.sv
`default_nettype none
// ============================================================================
// Module  : tpx3_data_in_tx_if
// Brief   : Byte stream (valid/ready/last) from the command FIFO.
// Revision: 1.0 - initial release
// ============================================================================
interface tpx3_data_in_tx_if
    import tpx3_tx_pkg::*;
;
    logic [c_byte_w-1:0] S_DATA;
    logic                S_VALID;
    logic                S_LAST;
    logic                S_READY;

    modport master (output S_DATA, output S_VALID, output S_LAST, input S_READY);
    modport slave  (input S_DATA, input S_VALID, input S_LAST, output S_READY);
endinterface
`default_nettype wire

// File: rtl/tpx3_tx_shifter.sv
`default_nettype none
// ============================================================================
// Module  : tpx3_tx_shifter
// Brief   : MSB-first byte shift register with bit counter and byte-end flag.
// Revision: 1.0 - initial release
// ============================================================================
module tpx3_tx_shifter
    import tpx3_tx_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_load,
    input  logic                i_shift,
    input  logic [c_byte_w-1:0] i_data,
    output logic                o_msb,
    output logic                o_byte_end
);

    logic [c_byte_w-1:0] r_shreg;
    logic [c_bcnt_w-1:0] r_bit_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (i_load) begin
            r_shreg   <= i_data;
            r_bit_cnt <= '1;
        end else if (i_shift) begin
            r_shreg   <= {r_shreg[c_byte_w-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt - 1'b1;
        end
    end

    assign o_msb      = r_shreg[c_byte_w-1];
    assign o_byte_end = (r_bit_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/tpx3_data_in_tx.sv
`default_nettype none
// ============================================================================
// Module  : tpx3_data_in_tx
// Brief   : Frames command bytes with EnableIn and serialises them MSB-first.
// Revision: 1.0 - initial release
// ============================================================================
module tpx3_data_in_tx
    import tpx3_tx_pkg::*;
#(
    parameter int LEAD_CYCLES  = 4,
    parameter int TRAIL_CYCLES = 4,
    parameter bit INVERT_DATA  = 1'b0,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    tpx3_data_in_tx_if.slave      s_if,
    output logic                  DATA_OUT,
    output logic                  EN_OUT,
    output logic                  BUSY,
    output logic                  PKT_DONE,
    output logic                  ERR,
    input  logic                  CLR_ERR,
    output logic [CNT_WIDTH-1:0]  BYTE_CNT
);

    localparam int c_lt_max = (LEAD_CYCLES > TRAIL_CYCLES) ? LEAD_CYCLES : TRAIL_CYCLES;
    localparam int c_lt_w   = (c_lt_max > 2) ? $clog2(c_lt_max) : 1;
    localparam logic [c_lt_w-1:0] c_lead_ld  = c_lt_w'((LEAD_CYCLES  > 0) ? LEAD_CYCLES  - 1 : 0);
    localparam logic [c_lt_w-1:0] c_trail_ld = c_lt_w'((TRAIL_CYCLES > 0) ? TRAIL_CYCLES - 1 : 0);

    tx_state_t           r_state, w_state_nxt;
    logic [c_lt_w-1:0]   r_lt_cnt, w_lt_cnt_nxt;
    logic                r_last;
    logic                r_normal_end;
    logic                w_load, w_shift, w_underrun, w_normal_end;
    logic                w_msb, w_byte_end;
    logic                w_hs;

    // Ready only where a byte can be taken without breaking the bitstream.
    assign s_if.S_READY = RST_N && ((r_state == ST_IDLE) ||
                          ((r_state == ST_SHIFT) && w_byte_end && !r_last));
    assign w_hs = s_if.S_VALID && s_if.S_READY;
    assign BUSY = (r_state != ST_IDLE);

    tpx3_tx_shifter u_shifter (
        .i_clk      (CLK),
        .i_rst_n    (RST_N),
        .i_load     (w_load),
        .i_shift    (w_shift),
        .i_data     (s_if.S_DATA),
        .o_msb      (w_msb),
        .o_byte_end (w_byte_end)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state  <= ST_IDLE;
            r_lt_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_lt_cnt <= w_lt_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_lt_cnt_nxt = r_lt_cnt;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_underrun   = 1'b0;
        w_normal_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    w_load = 1'b1;
                    if (LEAD_CYCLES > 0) begin
                        w_state_nxt  = ST_LEAD;
                        w_lt_cnt_nxt = c_lead_ld;
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end
            end
            ST_LEAD: begin
                if (r_lt_cnt == '0) w_state_nxt = ST_SHIFT;
                else                w_lt_cnt_nxt = r_lt_cnt - 1'b1;
            end
            ST_SHIFT: begin
                if (!w_byte_end) begin
                    w_shift = 1'b1;
                end else if (r_last) begin
                    if (TRAIL_CYCLES > 0) begin
                        w_state_nxt  = ST_TRAIL;
                        w_lt_cnt_nxt = c_trail_ld;
                    end else begin
                        w_state_nxt  = ST_IDLE;
                        w_normal_end = 1'b1;
                    end
                end else if (s_if.S_VALID) begin
                    w_load = 1'b1;
                end else begin
                    w_underrun  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_TRAIL: begin
                if (r_lt_cnt == '0) begin
                    w_state_nxt  = ST_IDLE;
                    w_normal_end = 1'b1;
                end else begin
                    w_lt_cnt_nxt = r_lt_cnt - 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output registers follow the current state, so the frame lags the FSM by one cycle.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            DATA_OUT     <= INVERT_DATA;
            EN_OUT       <= 1'b0;
            PKT_DONE     <= 1'b0;
            ERR          <= 1'b0;
            BYTE_CNT     <= '0;
            r_last       <= 1'b0;
            r_normal_end <= 1'b0;
        end else begin
            DATA_OUT     <= INVERT_DATA ^ ((r_state == ST_SHIFT) && w_msb);
            EN_OUT       <= (r_state != ST_IDLE);
            r_normal_end <= w_normal_end;
            PKT_DONE     <= r_normal_end;
            if (w_load) r_last <= s_if.S_LAST;
            if (w_underrun)   ERR <= 1'b1;
            else if (CLR_ERR) ERR <= 1'b0;
            if (w_load && (r_state == ST_IDLE))
                BYTE_CNT <= '0;
            else if ((r_state == ST_SHIFT) && w_byte_end && (BYTE_CNT != {CNT_WIDTH{1'b1}}))
                BYTE_CNT <= BYTE_CNT + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tpx3_data_in_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_tpx3_data_in_tx
// Brief   : Self-checking bench; three DUT variants share one stimulus driver.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tpx3_data_in_tx;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int        sel;
    logic [7:0] sdata;
    logic      svalid, slast, clr;
    int        n_chk = 0;
    int        n_fail = 0;

    // Per-variant framing: {lead, trail, invert}
    int lead_of [3] = '{4, 0, 2};
    int trail_of[3] = '{4, 0, 3};
    bit inv_of  [3] = '{1'b0, 1'b0, 1'b1};
    bit mdl_err [3];

    tpx3_data_in_tx_if if0();
    tpx3_data_in_tx_if if1();
    tpx3_data_in_tx_if if2();

    logic [2:0]  en_v, dat_v, busy_v, done_v, err_v, clr_v, rdy_v;
    logic [15:0] bc0, bc1, bc2, bc;
    logic        rdy, en, dat, busy, done, err;

    assign if0.S_DATA = sdata;  assign if0.S_LAST = slast;  assign if0.S_VALID = svalid && (sel == 0);
    assign if1.S_DATA = sdata;  assign if1.S_LAST = slast;  assign if1.S_VALID = svalid && (sel == 1);
    assign if2.S_DATA = sdata;  assign if2.S_LAST = slast;  assign if2.S_VALID = svalid && (sel == 2);
    assign rdy_v = {if2.S_READY, if1.S_READY, if0.S_READY};
    assign clr_v = {clr && (sel == 2), clr && (sel == 1), clr && (sel == 0)};

    assign rdy  = rdy_v[sel];
    assign en   = en_v[sel];
    assign dat  = dat_v[sel];
    assign busy = busy_v[sel];
    assign done = done_v[sel];
    assign err  = err_v[sel];
    assign bc   = (sel == 0) ? bc0 : (sel == 1) ? bc1 : bc2;

    tpx3_data_in_tx #(.LEAD_CYCLES(4), .TRAIL_CYCLES(4), .INVERT_DATA(1'b0), .CNT_WIDTH(16)) u_dut0 (
        .CLK(clk), .RST_N(rst_n), .s_if(if0), .DATA_OUT(dat_v[0]), .EN_OUT(en_v[0]), .BUSY(busy_v[0]),
        .PKT_DONE(done_v[0]), .ERR(err_v[0]), .CLR_ERR(clr_v[0]), .BYTE_CNT(bc0));
    tpx3_data_in_tx #(.LEAD_CYCLES(0), .TRAIL_CYCLES(0), .INVERT_DATA(1'b0), .CNT_WIDTH(16)) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .s_if(if1), .DATA_OUT(dat_v[1]), .EN_OUT(en_v[1]), .BUSY(busy_v[1]),
        .PKT_DONE(done_v[1]), .ERR(err_v[1]), .CLR_ERR(clr_v[1]), .BYTE_CNT(bc1));
    tpx3_data_in_tx #(.LEAD_CYCLES(2), .TRAIL_CYCLES(3), .INVERT_DATA(1'b1), .CNT_WIDTH(16)) u_dut2 (
        .CLK(clk), .RST_N(rst_n), .s_if(if2), .DATA_OUT(dat_v[2]), .EN_OUT(en_v[2]), .BUSY(busy_v[2]),
        .PKT_DONE(done_v[2]), .ERR(err_v[2]), .CLR_ERR(clr_v[2]), .BYTE_CNT(bc2));

    typedef struct {
        int          s;
        int          n;
        logic [23:0] pk;
        int          k;
        bit          clr_u;
        bit          clr_a;
        int          en_cyc;
        int          bc;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input int j, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut=%0d cyc=%0d got=%0h want=%0h", name, sel, j, act, exp);
        end
    endtask

    // Sends one packet of n bytes; byte k is withheld (underrun) when k < n.
    task automatic run_pkt(input int s, input int n, input logic [23:0] pk, input int k,
                           input bit clr_u, input bit clr_a, input int exp_en, input int exp_bc);
        int L, T, nb, rp, E, ptr, en_cnt, tmo, bi, rel, bexp;
        bit und, inv, e_dat;
        und = (k < n);
        nb  = und ? k : n;
        rp  = und ? nb : nb - 1;
        L   = lead_of[s];
        T   = und ? 0 : trail_of[s];
        inv = inv_of[s];
        E   = L + 8 * nb + T;
        sel = s;
        @(negedge clk);
        tmo = 0;
        while (!rdy && tmo < 64) begin
            @(negedge clk);
            tmo++;
        end
        n_chk++;
        if (!rdy) begin
            n_fail++;
            $display("FAIL start_timeout dut=%0d got=0 want=1", s);
            return;
        end
        sdata  = pk[23 -: 8];
        slast  = (n == 1);
        svalid = 1'b1;
        ptr    = 1;
        en_cnt = 0;
        for (int j = 0; j <= E + 2; j++) begin
            @(negedge clk);
            e_dat = 1'b0;
            if (j >= L + 1 && j <= L + 8 * nb) begin
                bi    = j - L - 1;
                e_dat = pk[23 - 8 * (bi / 8) - (bi % 8)];
            end
            rel  = j + 1 - L;
            bexp = (j < L) ? 0 : (((j - L) / 8 > nb) ? nb : (j - L) / 8);
            chk("en_out",   j, en,   (j >= 1 && j <= E));
            chk("data_out", j, dat,  e_dat ^ inv);
            chk("pkt_done", j, done, (!und && j == E + 1));
            chk("busy",     j, busy, (j < E));
            chk("s_ready",  j, rdy,  (j >= E) || (rel > 0 && rel % 8 == 0 && rel / 8 <= rp));
            chk("err",      j, err,  (und && j >= E) ? 1'b1 : mdl_err[s]);
            chk("byte_cnt", j, bc,   bexp);
            if (en) en_cnt++;
            clr = 1'b0;
            if (rdy && ptr < n && ptr != k) begin
                sdata  = pk[23 - 8 * ptr -: 8];
                slast  = (ptr == n - 1);
                svalid = 1'b1;
                ptr++;
            end else begin
                svalid = rdy ? 1'b0 : 1'($urandom % 2);
                sdata  = 8'($urandom);
                slast  = 1'($urandom);
                if (und && j == E - 1 && clr_u) clr = 1'b1;
            end
        end
        svalid = 1'b0;
        clr    = 1'b0;
        if (und) mdl_err[s] = 1'b1;
        chk("en_cycles", E, en_cnt, exp_en);
        chk("final_cnt", E, bc, exp_bc);
        if (clr_a) begin
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
            mdl_err[s] = 1'b0;
            chk("err_clear", E, err, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int s, n, k, nb, en_c;
        bit und;
        logic [23:0] pk;

        tbl[0] = '{0, 1, 24'hA50000, 1, 1'b0, 1'b0, 16, 1};
        tbl[1] = '{0, 3, 24'h123456, 3, 1'b0, 1'b0, 32, 3};
        tbl[2] = '{0, 2, 24'h669900, 1, 1'b0, 1'b1, 12, 1};
        tbl[3] = '{0, 2, 24'h112200, 1, 1'b0, 1'b0, 12, 1};
        tbl[4] = '{0, 3, 24'hAABBCC, 2, 1'b1, 1'b1, 20, 2};
        tbl[5] = '{1, 1, 24'hFF0000, 1, 1'b0, 1'b0, 8, 1};
        tbl[6] = '{2, 1, 24'h0F0000, 1, 1'b0, 1'b0, 13, 1};
        tbl[7] = '{1, 2, 24'hC35A00, 1, 1'b0, 1'b1, 8, 1};
        tbl[8] = '{2, 3, 24'h817E55, 3, 1'b0, 1'b0, 29, 3};

        sel = 0; sdata = 8'h00; svalid = 1'b0; slast = 1'b0; clr = 1'b0;
        mdl_err = '{1'b0, 1'b0, 1'b0};
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            sel = d;
            #1;
            chk("rst_en",    d, en,   1'b0);
            chk("rst_data",  d, dat,  inv_of[d]);
            chk("rst_done",  d, done, 1'b0);
            chk("rst_err",   d, err,  1'b0);
            chk("rst_cnt",   d, bc,   0);
            chk("rst_ready", d, rdy,  1'b0);
            chk("rst_busy",  d, busy, 1'b0);
        end
        sel = 0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 0, rdy, 1'b1);

        for (int i = 0; i < 9; i++)
            run_pkt(tbl[i].s, tbl[i].n, tbl[i].pk, tbl[i].k, tbl[i].clr_u, tbl[i].clr_a,
                    tbl[i].en_cyc, tbl[i].bc);

        // Reset in the middle of byte 0 of a two-byte packet.
        sel = 0;
        @(negedge clk);
        sdata = 8'h3C; slast = 1'b0; svalid = 1'b1;
        @(negedge clk);
        svalid = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_abort_en", 8, en, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_en",    9, en,   1'b0);
        chk("abort_cnt",   9, bc,   0);
        chk("abort_busy",  9, busy, 1'b0);
        chk("abort_done",  9, done, 1'b0);
        chk("abort_ready", 9, rdy,  1'b0);
        rst_n = 1'b1;
        mdl_err = '{1'b0, 1'b0, 1'b0};
        @(negedge clk);
        chk("abort_done2", 10, done, 1'b0);
        run_pkt(0, 2, 24'hC33C00, 2, 1'b0, 1'b0, 24, 2);

        for (int r = 0; r < 14; r++) begin
            s   = int'($urandom_range(0, 2));
            n   = int'($urandom_range(1, 3));
            und = (n > 1) && ($urandom % 4 == 0);
            k   = und ? int'($urandom_range(1, n - 1)) : n;
            nb  = und ? k : n;
            pk  = 24'($urandom);
            en_c = lead_of[s] + 8 * nb + (und ? 0 : trail_of[s]);
            run_pkt(s, n, pk, k, 1'b0, und, en_c, nb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
